oscan1_format_ctrl: RTL
=======================

# oscan1_format_ctrl

Parametrised next-generation OScan1 target-side controller for the cJTAG two-wire port. It replaces counted-edge attention detection with true escape detection: TMSC toggles counted while TCKC is high. It receives a multi-bit command after a selection escape and decodes either SF0 (write-only) or SF1 (three-phase nTDI/TMS/TDO with TDO return) into JTAG TCK/TMS/TDI pulses for the downstream TAP. It sits between the cJTAG pad logic and the TAP controller, in the same clock domain as the TAP.

## Interface
- CMD_BITS, 4: command length in bits, received LSB first; legal range 2..8.
- TCK_PULSE, 2: jtag_tck high time in clk cycles; legal range 1..8.
- CNT_W, 16: width of bit_count.
- ESC_DESEL_MIN, 4: minimum toggle count for a deselection escape.
- ESC_SEL_MIN, 6: minimum toggle count for a selection escape.
- ESC_RESET_MIN, 8: minimum toggle count for a reset escape.
- Parameter constraint: ESC_DESEL_MIN < ESC_SEL_MIN < ESC_RESET_MIN ≤ 15.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tckc  in  1  cJTAG clock; asynchronous input.
- tmsc_in  in  1  cJTAG data; asynchronous input.
- tmsc_out  out  1  TDO return data.
- tmsc_oen  out  1  output enable, active-low (1 = tristate).
- jtag_tck  out  1  TCK pulse to the TAP.
- jtag_tms  out  1  TMS to the TAP; valid while jtag_tck is high.
- jtag_tdi  out  1  TDI to the TAP; valid while jtag_tck is high.
- jtag_tdo  in  1  TDO from the TAP.
- online  out  1  high in SF0 or SF1.
- format  out  2  0 = offline/cmd, 1 = SF0, 2 = SF1.
- cmd_error  out  1  sticky unsupported-command flag.
- bit_count  out  CNT_W  saturating count of issued jtag_tck pulses.

## Operation
- tckc and tmsc_in each pass through a 2-flop synchroniser. Edges are detected on the synchronised values; a registered edge flag follows 3 clk cycles after the pin change.
- Escape counter, 4 bits, saturating at 15:
  - Cleared on each TCKC rise.
  - Incremented on each synchronised TMSC edge while TCKC is high.
- At each TCKC fall, the escape count is evaluated before any data handling:
  - count ≥ ESC_RESET_MIN: go to OFFLINE; clear cmd_error and bit_count.
  - count ≥ ESC_SEL_MIN: go to CMD; clear cmd_error.
  - count ≥ ESC_DESEL_MIN: go to OFFLINE.
  - In all three cases above, this fall's data phase is discarded and no TCK pulse is issued.
  - count < ESC_DESEL_MIN: normal data handling.
- States:
  - OFFLINE: tmsc_oen = 1; only escapes act.
  - CMD: tmsc_in is sampled on each TCKC rise and shifted in LSB first. After CMD_BITS samples, the command is decoded in the next clk:
    - 0: OFFLINE.
    - 1: SF0.
    - 2: SF1.
    - all-ones: NOP, return to the format active before the escape (OFFLINE if none).
    - any other value: set cmd_error and stay in CMD with the shift counter cleared.
  - SF0, one TCKC period per JTAG bit:
    - TMS is sampled at the rise; TDI is sampled at the fall.
    - After the fall, jtag_tck pulses.
    - tmsc_oen stays 1 in SF0.
  - SF1, three TCKC periods per JTAG bit, phase counter 0..2:
    - Phase 0 rise: sample nTDI; jtag_tdi is its inverse.
    - Phase 1 rise: sample TMS, then issue the TCK pulse. jtag_tdo is captured on the clk where jtag_tck falls.
    - From the phase 1 TCKC fall until the phase 2 TCKC fall: tmsc_out = captured TDO and tmsc_oen = 0.
    - Any escape returns the phase counter to 0.
- bit_count increments on each jtag_tck rise and saturates at 2^CNT_W−1.

## Timing
- jtag_tck rises 1 clk after the triggering registered TCKC edge flag, and is high for exactly TCK_PULSE cycles.
- jtag_tms and jtag_tdi are updated on the same clk as the jtag_tck rise and hold until the next pulse.
- tmsc_oen changes on the clk after the registered TCKC fall flag.
- Requirement on the host: each TCKC half-period is at least TCK_PULSE+5 clk cycles.
- Reset (synchronous; also applies mid-pulse or mid-command), effective at the next clk edge:
  - state OFFLINE; synchronisers 0.
  - jtag_tck = 0, jtag_tms = 1, jtag_tdi = 0.
  - tmsc_out = 0, tmsc_oen = 1.
  - online = 0, format = 0, cmd_error = 0, bit_count = 0.
- Simultaneous events:
  - Escape evaluation at a TCKC fall overrides data handling on that fall.
  - A pulse already in progress completes its TCK_PULSE cycles.
  - An SF1 TDO drive window is cut short: tmsc_oen = 1 on the next clk.

## Configuration
- OSCAN1_SF1_EN defined: SF1 logic is compiled in; command 2 enters SF1.
- OSCAN1_SF1_EN undefined: SF1 logic and the TDO return path are removed. Command 2 is treated as unsupported: cmd_error is set and the block stays in CMD. tmsc_oen is tied to 1 and tmsc_out to 0.

## Test plan
- 6 TMSC toggles during TCKC high, then command 0x1 on 4 TCKC rises -> format = 1, online = 1, cmd_error = 0.
- In SF0, TMS = 1 at rise and TDI = 0 at fall, ×3 bits -> three jtag_tck pulses of exactly 2 clks with tms = 1 and tdi = 0; bit_count = 3; tmsc_oen stays 1.
- In SF1 with jtag_tdo = 1, send nTDI = 0 and TMS = 0 -> jtag_tdi = 1 and jtag_tms = 0. tmsc_oen = 0 and tmsc_out = 1 from the phase 1 fall to the phase 2 fall.
- Command 0x5 -> cmd_error = 1 and state stays CMD. A following command 0x2 -> SF1 (or cmd_error held if OSCAN1_SF1_EN is undefined).
- 3 toggles while online -> no state change. 4 toggles -> OFFLINE. 9 toggles -> OFFLINE with bit_count = 0.
- rst_n low for 1 clk during the SF1 TDO drive -> next clk: tmsc_oen = 1, jtag_tms = 1, format = 0.

Source files
------------

// File: rtl/oscan1_format_ctrl.sv
// rtl/oscan1_format_ctrl.sv - OScan1 target controller: escape detection, command decode, SF0/SF1 to JTAG
// SF1 and the TDO return path are compiled in only when OSCAN1_SF1_EN is defined.
module oscan1_format_ctrl #(
  parameter int CMD_BITS      = 4,
  parameter int TCK_PULSE     = 2,
  parameter int CNT_W         = 16,
  parameter int ESC_DESEL_MIN = 4,
  parameter int ESC_SEL_MIN   = 6,
  parameter int ESC_RESET_MIN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tckc,
  input  logic             tmsc_in,
  output logic             tmsc_out,
  output logic             tmsc_oen,
  output logic             jtag_tck,
  output logic             jtag_tms,
  output logic             jtag_tdi,
  input  logic             jtag_tdo,
  output logic             online,
  output logic [1:0]       format,
  output logic             cmd_error,
  output logic [CNT_W-1:0] bit_count
);
  typedef enum logic [1:0] {ST_OFFLINE, ST_CMD, ST_SF0, ST_SF1} state_t;

  state_t state, state_n, prev_state;
  logic tckc_m, tckc_s, tckc_d, tmsc_m, tmsc_s, tmsc_d;
  logic tckc_rise, tckc_fall, tmsc_edge;
  logic [3:0] esc_cnt;
  logic [CMD_BITS-1:0] shreg;
  logic [3:0] shcnt;
  logic rise_seen, tms_q;
  logic [2:0] pulse_cnt;
  logic esc_any, esc_sel, esc_reset, data_fall, cmd_done, cmd_bad;
  logic fire, fire_tms, fire_tdi;
`ifdef OSCAN1_SF1_EN
  logic [1:0] phase;
  logic ntdi_q, tdo_cap;
`else
  logic unused_tdo;
  assign unused_tdo = jtag_tdo;
  assign tmsc_oen   = 1'b1;
  assign tmsc_out   = 1'b0;
`endif

  assign online = (state == ST_SF0) || (state == ST_SF1);

  always_comb begin
    esc_any   = tckc_fall && (esc_cnt >= 4'(ESC_DESEL_MIN));
    esc_sel   = esc_any && (esc_cnt >= 4'(ESC_SEL_MIN));
    esc_reset = esc_any && (esc_cnt >= 4'(ESC_RESET_MIN));
    // A data fall only counts if its period's rise was also seen in a data format.
    data_fall = tckc_fall && !esc_any && rise_seen;
    cmd_done  = (state == ST_CMD) && (shcnt == 4'(CMD_BITS));
    cmd_bad   = 1'b1;
    if (shreg == CMD_BITS'(0) || shreg == CMD_BITS'(1) || shreg == '1) cmd_bad = 1'b0;
`ifdef OSCAN1_SF1_EN
    if (shreg == CMD_BITS'(2)) cmd_bad = 1'b0;
`endif
    fire     = 1'b0;
    fire_tms = tms_q;
    fire_tdi = tmsc_d;
    if (state == ST_SF0 && data_fall) fire = 1'b1;
`ifdef OSCAN1_SF1_EN
    if (state == ST_SF1 && tckc_rise && phase == 2'd1) begin
      fire     = 1'b1;
      fire_tms = tmsc_d;
      fire_tdi = ~ntdi_q;
    end
`endif
    state_n = state;
    if (esc_reset) state_n = ST_OFFLINE;
    else if (esc_sel) state_n = ST_CMD;
    else if (esc_any) state_n = ST_OFFLINE;
    else if (cmd_done) begin
      if (shreg == CMD_BITS'(0)) state_n = ST_OFFLINE;
      else if (shreg == CMD_BITS'(1)) state_n = ST_SF0;
      else if (shreg == '1) state_n = prev_state;
`ifdef OSCAN1_SF1_EN
      else if (shreg == CMD_BITS'(2)) state_n = ST_SF1;
`endif
    end
    case (state)
      ST_SF0:  format = 2'd1;
      ST_SF1:  format = 2'd2;
      default: format = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_OFFLINE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {tckc_m, tckc_s, tckc_d, tmsc_m, tmsc_s, tmsc_d} <= '0;
      {tckc_rise, tckc_fall, tmsc_edge} <= '0;
      esc_cnt    <= '0;
      shreg      <= '0;
      shcnt      <= '0;
      rise_seen  <= 1'b0;
      tms_q      <= 1'b1;
      pulse_cnt  <= '0;
      prev_state <= ST_OFFLINE;
      jtag_tck   <= 1'b0;
      jtag_tms   <= 1'b1;
      jtag_tdi   <= 1'b0;
      cmd_error  <= 1'b0;
      bit_count  <= '0;
    end else begin
      tckc_m    <= tckc;
      tckc_s    <= tckc_m;
      tckc_d    <= tckc_s;
      tmsc_m    <= tmsc_in;
      tmsc_s    <= tmsc_m;
      tmsc_d    <= tmsc_s;
      tckc_rise <= tckc_s & ~tckc_d;
      tckc_fall <= ~tckc_s & tckc_d;
      tmsc_edge <= tmsc_s ^ tmsc_d;

      if (tckc_rise) esc_cnt <= '0;
      else if (tmsc_edge && tckc_d && esc_cnt != 4'hf) esc_cnt <= esc_cnt + 4'd1;

      if (tckc_rise) rise_seen <= online;
      else if (tckc_fall) rise_seen <= 1'b0;

      if (tckc_rise && state == ST_SF0) tms_q <= tmsc_d;
      if (tckc_rise && state == ST_CMD) begin
        shreg <= {tmsc_d, shreg[CMD_BITS-1:1]};
        shcnt <= shcnt + 4'd1;
      end
      if (cmd_done) begin
        shcnt <= '0;
        if (cmd_bad) cmd_error <= 1'b1;
      end

      if (jtag_tck) begin
        if (pulse_cnt == 3'd0) jtag_tck <= 1'b0;
        else pulse_cnt <= pulse_cnt - 3'd1;
      end else if (fire) begin
        jtag_tck  <= 1'b1;
        pulse_cnt <= 3'(TCK_PULSE - 1);
        jtag_tms  <= fire_tms;
        jtag_tdi  <= fire_tdi;
        if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
      end

      if (esc_any) begin
        shcnt <= '0;
        if (esc_sel) begin
          cmd_error  <= 1'b0;
          prev_state <= online ? state : ST_OFFLINE;
        end
        if (esc_reset) bit_count <= '0;
      end
    end
  end

`ifdef OSCAN1_SF1_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= 2'd0;
      ntdi_q   <= 1'b0;
      tdo_cap  <= 1'b0;
      tmsc_out <= 1'b0;
      tmsc_oen <= 1'b1;
    end else begin
      if (jtag_tck && pulse_cnt == 3'd0) tdo_cap <= jtag_tdo;
      if (tckc_rise && state == ST_SF1 && phase == 2'd0) ntdi_q <= tmsc_d;
      if (cmd_done) phase <= 2'd0;
      if (data_fall && state == ST_SF1) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        if (phase == 2'd1) begin
          tmsc_oen <= 1'b0;
          tmsc_out <= tdo_cap;
        end else begin
          tmsc_oen <= 1'b1;
        end
      end
      if (esc_any) begin
        phase    <= 2'd0;
        tmsc_oen <= 1'b1;
      end
    end
  end
`endif
endmodule
